seven_seg_mux: RTL and testbench

Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits sharing one segment bus. It takes a packed vector of hex nibbles and scans the digits one at a time at a programmable refresh rate. A programmable blanking interval between digits suppresses ghosting, and digits can be blanked individually. It sits between the board-level display pins and any logic producing hex values, and replaces a single-digit static decode.

---
 rtl/seven_seg_pkg.sv | 24 ++
 rtl/seven_seg_mux_if.sv | 22 ++
 rtl/seven_seg_decode.sv | 11 +
 rtl/seven_seg_mux.sv | 117 +++++++++++
 tb/tb_seven_seg_mux.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver:
// segment lookup table, unlit pattern and the slot phase encoding.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } phase_t;

  // Active-high unlit pattern; polarity is applied at the pins.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high gfedcba patterns, entry 15 first so SEG_LUT[n] is hex digit n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] apply_seg_polarity(input logic [6:0] pattern,
                                                    input logic       active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/seven_seg_mux_if.sv
// Display-side bundle: hex data and per-digit controls in, segment/anode pins out.
interface seven_seg_mux_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [6:0]              seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    frame_start;

  modport master (
    output digits, dp, digit_en,
    input  seg, dp_out, anode, frame_start
  );

  modport slave (
    input  digits, dp, digit_en,
    output seg, dp_out, anode, frame_start
  );
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = SEG_LUT[nibble];

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed common-anode seven-segment scanner with per-slot blanking
// and per-digit enables; all pin outputs are registered.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 24000,
  parameter int BLANK_CYCLES   = 240,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic           clk,
  input logic           reset,
  seven_seg_mux_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_ON      = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam phase_t                RESET_PHASE = (BLANK_CYCLES == 0) ? ON : BLANK;
  localparam logic                  SEG_LOW     = (SEG_ACTIVE_LOW != 0);
  localparam logic                  AN_LOW      = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_UNLIT   = SEG_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DP_UNLIT    = SEG_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF      = AN_LOW ? '1 : '0;

  // cnt/idx name the counter position that the next edge will present.
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  phase_t                phase_q, phase_d;

  logic [3:0]            cap_nib;
  logic                  cap_dp;
  logic                  cap_en;

  logic                  capture;
  logic [3:0]            src_nib;
  logic                  src_dp;
  logic                  src_en;
  logic [6:0]            dec_pat;
  logic [NUM_DIGITS-1:0] anode_sel;

  // Phase FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= RESET_PHASE;
    else       phase_q <= phase_d;
  end

  // Phase FSM: next state and capture/source selection.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    phase_d   = ON;
    capture   = 1'b0;
    anode_sel = '0;
    if (cnt < CNT_ON) phase_d = BLANK;
    // Entering ON is a BLANK->ON step, or the slot boundary when there is no blanking.
    if (phase_d == ON && (phase_q == BLANK || cnt == '0)) capture = 1'b1;
    anode_sel[idx] = 1'b1;
  end

  // The capturing edge drives the pins from live inputs, so data and anode move together.
  assign src_nib = capture ? bus.digits[4*int'(idx) +: 4] : cap_nib;
  assign src_dp  = capture ? bus.dp[idx]       : cap_dp;
  assign src_en  = capture ? bus.digit_en[idx] : cap_en;

  seven_seg_decode u_decode (
    .nibble  (src_nib),
    .pattern (dec_pat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      idx     <= '0;
      cap_nib <= '0;
      cap_dp  <= 1'b0;
      cap_en  <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        cap_nib <= src_nib;
        cap_dp  <= src_dp;
        cap_en  <= src_en;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.anode       <= AN_OFF;
      bus.seg         <= SEG_UNLIT;
      bus.dp_out      <= DP_UNLIT;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= (cnt == '0) && (idx == '0);
      if (phase_d == ON && src_en) begin
        bus.anode  <= AN_LOW ? ~anode_sel : anode_sel;
        bus.seg    <= apply_seg_polarity(dec_pat, SEG_LOW);
        bus.dp_out <= SEG_LOW ? ~src_dp : src_dp;
      end else begin
        bus.anode  <= AN_OFF;
        bus.seg    <= SEG_UNLIT;
        bus.dp_out <= DP_UNLIT;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: position-based reference model compared every cycle,
// plus hand-computed literal checks for reset, scan order, decode, capture and blanking.
module tb_seven_seg_mux;

  localparam int ND = 2;
  localparam int RD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seven_seg_mux_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_mux #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BC),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t edge=%0d: got %h, expected %h", name, $time, edge_n, act, exp);
    end
  endtask

  // Active-high gfedcba reference patterns for hex 0..F.
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: derive the display from the counter position p of each edge.
  int         m_edges;
  logic [3:0] m_nib;
  logic       m_dp;
  logic       m_en;
  logic [1:0] exp_anode;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic       exp_fs;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges   = 0;
      m_nib     = 4'h0;
      m_dp      = 1'b0;
      m_en      = 1'b0;
      exp_anode = 2'b11;
      exp_seg   = 7'h7F;
      exp_dp    = 1'b1;
      exp_fs    = 1'b0;
    end else begin
      int p, c, d;
      p = m_edges;
      m_edges++;
      c = p % RD;
      d = (p / RD) % ND;
      exp_fs = ((p % (ND * RD)) == 0);
      if (c == BC) begin
        m_nib = bus.digits[4*d +: 4];
        m_dp  = bus.dp[d];
        m_en  = bus.digit_en[d];
      end
      if (c < BC || !m_en) begin
        exp_anode = 2'b11;
        exp_seg   = 7'h7F;
        exp_dp    = 1'b1;
      end else begin
        exp_anode = ~(2'b01 << d);
        exp_seg   = ~lut[m_nib];
        exp_dp    = ~m_dp;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_anode", 32'(bus.anode), 32'(exp_anode));
      check("model_seg", 32'(bus.seg), 32'(exp_seg));
      check("model_dp_out", 32'(bus.dp_out), 32'(exp_dp));
      check("model_frame_start", 32'(bus.frame_start), 32'(exp_fs));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_anode", 32'(bus.anode), 32'h3);
    check("reset_seg", 32'(bus.seg), 32'h7F);
    @(negedge clk);
    #2 reset = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    reset        = 1'b0;
    bus.digits   = 8'h3A;
    bus.dp       = 2'b01;
    bus.digit_en = 2'b11;
    #2 reset = 1'b1;
    #1 chk_on = 1'b1;

    // Reset held, then released; scan order, decode and frame pulses.
    repeat (3) @(negedge clk);
    check("hold_anode", 32'(bus.anode), 32'h3);
    check("hold_seg", 32'(bus.seg), 32'h7F);
    check("hold_dp_out", 32'(bus.dp_out), 32'h1);
    check("hold_frame_start", 32'(bus.frame_start), 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 34; i++) begin
      tick();
      if (edge_n == 1 || edge_n == 17 || edge_n == 33)
        check("fs_pulse", 32'(bus.frame_start), 32'h1);
      if (edge_n == 2 || edge_n == 16 || edge_n == 18)
        check("fs_idle", 32'(bus.frame_start), 32'h0);
      if (edge_n == 3) begin
        check("d0_anode", 32'(bus.anode), 32'h2);
        check("d0_seg_A", 32'(bus.seg), 32'h08);
        check("d0_dp_lit", 32'(bus.dp_out), 32'h0);
      end
      if (edge_n == 9) check("gap_anode", 32'(bus.anode), 32'h3);
      if (edge_n == 11) begin
        check("d1_anode", 32'(bus.anode), 32'h1);
        check("d1_seg_3", 32'(bus.seg), 32'h30);
        check("d1_dp_dark", 32'(bus.dp_out), 32'h1);
      end
    end

    // Mid-slot data change only lands at each digit's next slot.
    bus.digits = 8'h00;
    bus.dp     = 2'b00;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (edge_n == 5) bus.digits = 8'h11;
      if (edge_n == 8) check("hold_old_seg", 32'(bus.seg), 32'h40);
      if (edge_n == 11) check("d1_new_seg", 32'(bus.seg), 32'h79);
      if (edge_n == 19) begin
        check("d0_new_anode", 32'(bus.anode), 32'h2);
        check("d0_new_seg", 32'(bus.seg), 32'h79);
      end
    end

    // Digit 0 disabled: its slot stays dark, timing unchanged.
    bus.digits   = 8'h5C;
    bus.digit_en = 2'b10;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      tick();
      if (edge_n == 3 || edge_n == 8 || edge_n == 21) begin
        check("dis_anode", 32'(bus.anode), 32'h3);
        check("dis_seg", 32'(bus.seg), 32'h7F);
      end
      if (edge_n == 11) begin
        check("en_anode", 32'(bus.anode), 32'h1);
        check("en_seg_5", 32'(bus.seg), 32'h12);
      end
      if (edge_n == 17 || edge_n == 33) check("dis_fs", 32'(bus.frame_start), 32'h1);
    end

    // Asynchronous reset mid-slot, then the scan restarts from edge 1.
    bus.digit_en = 2'b11;
    do_reset();
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("async_anode", 32'(bus.anode), 32'h3);
    check("async_seg", 32'(bus.seg), 32'h7F);
    @(negedge clk);
    #2 reset = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 16; i++) begin
      logic [1:0] want;
      tick();
      if (edge_n <= 2 || (edge_n >= 9 && edge_n <= 10)) want = 2'b11;
      else if (edge_n <= 8) want = 2'b10;
      else want = 2'b01;
      check("restart_anode", 32'(bus.anode), 32'(want));
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
